sha3_round_sequencer: RTL

Iteration controller that sits directly upstream of `sha3_iterable_round` and closes the loop around it. It accepts one 1600-bit Keccak state and issues it to the round with `round_index` 0. It feeds each round result back as the next round's input until round 23 completes, then presents the permuted state. One permutation is in flight at a time. The round's latency is never assumed: every step is paced by the round's `ogood`.

---
 rtl/sha3_round_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sha3_round_sequencer.sv
// Loop controller around sha3_iterable_round: issues a state LAST_ROUND+1 times,
// pacing each step on the round's rgood, then presents the permuted state.
module sha3_round_sequencer #(
    parameter int unsigned LAST_ROUND = 23,
    parameter int unsigned WATCHDOG   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0][63:0] isa,
    input  logic [4:0][63:0] isb,
    input  logic [4:0][63:0] isc,
    input  logic [4:0][63:0] isd,
    input  logic [4:0][63:0] ise,
    input  logic             sample,
    output logic             ready,
    output logic [4:0]       round_index,
    output logic [4:0][63:0] rsa,
    output logic [4:0][63:0] rsb,
    output logic [4:0][63:0] rsc,
    output logic [4:0][63:0] rsd,
    output logic [4:0][63:0] rse,
    output logic             rsample,
    input  logic [4:0][63:0] risa,
    input  logic [4:0][63:0] risb,
    input  logic [4:0][63:0] risc,
    input  logic [4:0][63:0] risd,
    input  logic [4:0][63:0] rise,
    input  logic             rgood,
    output logic [4:0][63:0] osa,
    output logic [4:0][63:0] osb,
    output logic [4:0][63:0] osc,
    output logic [4:0][63:0] osd,
    output logic [4:0][63:0] ose,
    output logic             ogood,
    output logic             overrun,
    output logic             stall
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    localparam int unsigned     WD_W     = (WATCHDOG > 1) ? $clog2(WATCHDOG) : 1;
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'((WATCHDOG == 0) ? 0 : WATCHDOG - 1);
    localparam logic [4:0]      LAST_IDX = 5'(LAST_ROUND);

    state_t          state_q;
    state_t          state_d;
    logic [WD_W-1:0] wd_q;
    logic            accept;
    logic            advance;
    logic            finish;
    logic            timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sample) begin
                    accept  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the expiry cycle still counts.
                if (rgood) begin
                    if (round_index == LAST_IDX) begin
                        finish  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        advance = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end else if (WATCHDOG != 0 && wd_q == WD_LAST) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ready   = (state_q == ST_IDLE);
    assign rsample = (state_q == ST_ISSUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            round_index <= '0;
            wd_q        <= '0;
            rsa         <= '0;
            rsb         <= '0;
            rsc         <= '0;
            rsd         <= '0;
            rse         <= '0;
            osa         <= '0;
            osb         <= '0;
            osc         <= '0;
            osd         <= '0;
            ose         <= '0;
            ogood       <= 1'b0;
            overrun     <= 1'b0;
            stall       <= 1'b0;
        end else begin
            ogood <= finish;
            if (sample && state_q != ST_IDLE) begin
                overrun <= 1'b1;
            end
            if (timeout) begin
                stall <= 1'b1;
            end
            if (accept) begin
                rsa         <= isa;
                rsb         <= isb;
                rsc         <= isc;
                rsd         <= isd;
                rse         <= ise;
                round_index <= '0;
            end
            if (advance) begin
                rsa         <= risa;
                rsb         <= risb;
                rsc         <= risc;
                rsd         <= risd;
                rse         <= rise;
                round_index <= round_index + 5'd1;
            end
            if (finish) begin
                osa <= risa;
                osb <= risb;
                osc <= risc;
                osd <= risd;
                ose <= rise;
            end
            if (state_q == ST_ISSUE) begin
                wd_q <= '0;
            end else if (state_q == ST_WAIT) begin
                wd_q <= wd_q + WD_W'(1);
            end
        end
    end

endmodule
